// File: rtl/reservation_entry_allocator_pkg.sv
// Shared scheduling definitions for the reservation station allocator.
// Entry counts, index widths, flag encodings and the free-count helper.
package reservation_entry_allocator_pkg;

  localparam int RS_ENTRY_NUM = 16;
  localparam int RS_IDX_W     = 4;
  localparam int RS_CNT_W     = 5;

  localparam logic FLAG_FREE = 1'b1;
  localparam logic FLAG_BUSY = 1'b0;

  // Counts free entries; 5 bits so a fully free station (16) cannot wrap.
  function automatic logic [RS_CNT_W-1:0] free_count(input logic [RS_ENTRY_NUM-1:0] vec);
    logic [RS_CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < RS_ENTRY_NUM; i++) begin
      sum = sum + {{(RS_CNT_W-1){1'b0}}, vec[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/reservation_entry_allocator_select.sv
// Combinational picker: lowest free entry, and the lowest free entry
// that remains once the first pick is excluded.
module reservation_entry_select
  import reservation_entry_allocator_pkg::*;
(
  input  logic [RS_ENTRY_NUM-1:0] free_vec,
  output logic                    first_found,
  output logic [RS_IDX_W-1:0]     first_idx,
  output logic                    second_found,
  output logic [RS_IDX_W-1:0]     second_idx
);

  logic [RS_ENTRY_NUM-1:0] excl_vec;

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = RS_ENTRY_NUM - 1; i >= 0; i--) begin
      if (free_vec[i] == FLAG_FREE) begin
        first_found = 1'b1;
        first_idx   = i[RS_IDX_W-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < RS_ENTRY_NUM; gi++) begin : g_excl
      assign excl_vec[gi] = free_vec[gi] & ~(first_found && (first_idx == RS_IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    second_found = 1'b0;
    second_idx   = '0;
    for (int i = RS_ENTRY_NUM - 1; i >= 0; i--) begin
      if (excl_vec[i] == FLAG_FREE) begin
        second_found = 1'b1;
        second_idx   = i[RS_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/reservation_entry_allocator.sv
// Free/busy bitmap owner for the 16-entry reservation station: two grants
// per cycle to dispatch, two releases per cycle from issue.
module reservation_entry_allocator
  import reservation_entry_allocator_pkg::*;
#(
  parameter int P_ENTRY = 16,
  parameter int P_IDX_W = 4
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iFLUSH,
  input  logic               iREQ_VALID0,
  input  logic               iREQ_VALID1,
  output logic               oREQ_LOCK,
  output logic               oALLOC_VALID0,
  output logic [P_IDX_W-1:0] oALLOC_ENTRY0,
  output logic               oALLOC_VALID1,
  output logic [P_IDX_W-1:0] oALLOC_ENTRY1,
  input  logic               iREL_VALID0,
  input  logic [P_IDX_W-1:0] iREL_ENTRY0,
  input  logic               iREL_VALID1,
  input  logic [P_IDX_W-1:0] iREL_ENTRY1,
  output logic [P_ENTRY-1:0] oFREE_INFO,
  output logic [RS_CNT_W-1:0] oFREE_COUNT,
  output logic               oREL_ERR
);

  logic [P_ENTRY-1:0]  free_reg, free_next;
  logic [RS_CNT_W-1:0] count_reg, count_next;
  logic                rel_err_reg, rel_err_next;

  logic                first_found, second_found;
  logic [P_IDX_W-1:0]  first_idx, second_idx;
  logic                grant_ok;

  reservation_entry_select u_select (
    .free_vec     (free_reg),
    .first_found  (first_found),
    .first_idx    (first_idx),
    .second_found (second_found),
    .second_idx   (second_idx)
  );

  // Lock looks only at registered state, so it lags releases by a cycle.
  assign oREQ_LOCK = (count_reg < RS_CNT_W'(2));
  assign grant_ok  = ~oREQ_LOCK & ~iFLUSH & ~iRESET_SYNC;

  assign oALLOC_VALID0 = iREQ_VALID0 & grant_ok & first_found;
  assign oALLOC_VALID1 = iREQ_VALID1 & grant_ok & (iREQ_VALID0 ? second_found : first_found);
  assign oALLOC_ENTRY0 = oALLOC_VALID0 ? first_idx : '0;
  assign oALLOC_ENTRY1 = oALLOC_VALID1 ? (iREQ_VALID0 ? second_idx : first_idx) : '0;

  always_comb begin
    free_next    = free_reg;
    rel_err_next = 1'b0;
    if (iFLUSH) begin
      free_next = '1;
    end else begin
      if (oALLOC_VALID0) free_next[oALLOC_ENTRY0] = FLAG_BUSY;
      if (oALLOC_VALID1) free_next[oALLOC_ENTRY1] = FLAG_BUSY;
      // Error test uses the pre-update bitmap so a doubled release of one busy entry is legal.
      if (iREL_VALID0) begin
        if (free_reg[iREL_ENTRY0] == FLAG_FREE) rel_err_next = 1'b1;
        else                                    free_next[iREL_ENTRY0] = FLAG_FREE;
      end
      if (iREL_VALID1) begin
        if (free_reg[iREL_ENTRY1] == FLAG_FREE) rel_err_next = 1'b1;
        else                                    free_next[iREL_ENTRY1] = FLAG_FREE;
      end
    end
    count_next = free_count(free_next);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      free_reg    <= '1;
      count_reg   <= RS_CNT_W'(RS_ENTRY_NUM);
      rel_err_reg <= 1'b0;
    end else begin
      free_reg    <= free_next;
      count_reg   <= count_next;
      rel_err_reg <= rel_err_next;
    end
  end

  assign oFREE_INFO  = free_reg;
  assign oFREE_COUNT = count_reg;
  assign oREL_ERR    = rel_err_reg;

endmodule
